// File: rtl/maindec_pipe.sv
// maindec_pipe: registered main decoder feeding the ID/EX control register.
// Decodes the opcode in ID, captures the control bundle with stall/flush/bubble
// handling, flags unimplemented opcodes and keeps a saturating count of them.
module maindec_pipe #(
    parameter int unsigned EXT_OPS = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [6:0]       op,
    output logic             out_valid,
    output logic             RegWrite,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       ALUSrcA,
    output logic             ALUSrcB,
    output logic             MemWrite,
    output logic [1:0]       ResultSrc,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             Jump,
    output logic             JumpReg,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Bundle layout, MSB first:
    // RegWrite, ImmSrc[2:0], ALUSrcA[1:0], ALUSrcB, MemWrite, ResultSrc[1:0],
    // Branch, ALUOp[1:0], Jump, JumpReg
    localparam int unsigned CtrlW = 15;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpNop   = 7'b0000000;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CtrlW-1:0] dec_ctrl;
    logic             dec_ill;

    logic [CtrlW-1:0] ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic             ill_d, ill_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Opcode decode; unimplemented opcodes give zero controls, never X.
    always_comb begin
        dec_ctrl = '0;
        dec_ill  = 1'b0;
        case (op)
            OpLoad:  dec_ctrl = 15'b1_000_00_1_0_01_0_00_0_0;
            OpStore: dec_ctrl = 15'b0_001_00_1_1_00_0_00_0_0;
            OpReg:   dec_ctrl = 15'b1_000_00_0_0_00_0_10_0_0;
            OpBr:    dec_ctrl = 15'b0_010_00_0_0_00_1_01_0_0;
            OpImm:   dec_ctrl = 15'b1_000_00_1_0_00_0_10_0_0;
            OpJal:   dec_ctrl = 15'b1_011_00_0_0_10_0_00_1_0;
            OpLui:   dec_ctrl = 15'b1_100_01_1_0_00_0_00_0_0;
            OpAuipc: begin
                if (EXT_OPS != 0) dec_ctrl = 15'b1_100_10_1_0_00_0_00_0_0;
                else              dec_ill  = 1'b1;
            end
            OpJalr: begin
                if (EXT_OPS != 0) dec_ctrl = 15'b1_000_00_1_0_10_0_00_1_1;
                else              dec_ill  = 1'b1;
            end
            OpNop:   dec_ctrl = '0;
            default: dec_ill  = 1'b1;
        endcase
    end

    // Next state: flush beats stall; stall holds everything including the counter.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (flush) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            ill_d   = 1'b0;
        end else if (!stall) begin
            if (!in_valid) begin
                ctrl_d  = '0;
                valid_d = 1'b0;
                ill_d   = 1'b0;
            end else begin
                ctrl_d  = dec_ctrl;
                valid_d = 1'b1;
                ill_d   = dec_ill;
                if (dec_ill && (cnt_q != CntMax)) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ID/EX control register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc,
            Branch, ALUOp, Jump, JumpReg} = ctrl_q;
    assign out_valid   = valid_q;
    assign illegal     = ill_q;
    assign illegal_cnt = cnt_q;

endmodule
